// File: rtl/l2_burst_adaptor.sv
// Adapts 256-bit L2 line reads/writes into four 64-bit memory beats; resp_o pulses one cycle after the last beat.
// Beats advance only on resp_i (gaps allowed); optional watchdog under `L2_BURST_TIMEOUT_EN` sets sticky err_o.
module l2_burst_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  input  logic         resp_i,
  output logic         err_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [31:0]  addr_q;
  logic [255:0] line_q;
  logic         busy;
  logic         timeout;
  logic         unused_addr;

  assign busy = (state == RD) || (state == WR);
  // Memory bursts are line-aligned, so the low address bits are dropped.
  assign unused_addr = &{1'b0, addr_q[4:0]};

`ifdef L2_BURST_TIMEOUT_EN
  logic [9:0] idle_cnt;
  logic       err_q;

  // Counter sits at zero outside a burst, so it is already clear on entry to RD/WR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else if (!busy) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= resp_i ? 10'd0 : idle_cnt + 10'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout = busy && !resp_i && (idle_cnt == 10'd1022);
  assign err_o   = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
      line_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            line_q <= line_i;
            addr_q <= address_i;
            cnt    <= '0;
            state  <= WR;
          end else if (read_i) begin
            addr_q <= address_i;
            cnt    <= '0;
            state  <= RD;
          end
        end
        RD, WR: begin
          if (resp_i) begin
            if (state == RD) line_o[{cnt, 6'b0} +: 64] <= burst_i;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end else if (timeout) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign address_o = busy ? {addr_q[31:5], 5'b0} : 32'd0;
  assign read_o    = (state == RD);
  assign write_o   = (state == WR);
  assign resp_o    = (state == DONE);
  assign burst_o   = (state == WR) ? line_q[{cnt, 6'b0} +: 64] : 64'd0;
endmodule
